// File: rtl/rr_handshake_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_handshake_arbiter
// Description : Round-robin merge of NUM_REQ valid/ready channels onto one
//               registered downstream channel. Multi-beat packets are not
//               interleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_handshake_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]       last_in,
    input  logic [NUM_REQ-1:0]       valid_up_in,
    output logic [NUM_REQ-1:0]       ready_up_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     last_out,
    output logic [IDW-1:0]           grant_id_out,
    output logic                     valid_down_out,
    input  logic                     ready_down_in
);

    localparam logic [0:0]     c_ST_ARB   = 1'b0;
    localparam logic [0:0]     c_ST_LOCK  = 1'b1;
    localparam logic [IDW-1:0] c_LAST_IDX = IDW'(NUM_REQ - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   w_owner_nxt;

    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [IDW-1:0]   r_id;
    logic             r_valid;

    logic [IDW-1:0]   w_arb_idx;
    logic             w_arb_found;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_win_inc;
    logic             w_win_valid;
    logic             w_win_last;
    logic [WIDTH-1:0] w_win_data;
    logic             w_can_load;
    logic             w_up_fire;

    // Rotating priority search: iterating from the far end lets the entry
    // closest to r_ptr overwrite the others.
    always_comb begin
        int idx;
        idx         = 0;
        w_arb_idx   = r_ptr;
        w_arb_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (valid_up_in[idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDW'(idx);
            end
        end
    end

    // In LOCK the owner is the sole candidate, even when it is not valid.
    assign w_win       = (r_state == c_ST_LOCK) ? r_owner : w_arb_idx;
    assign w_win_valid = (r_state == c_ST_LOCK) ? valid_up_in[r_owner] : w_arb_found;
    assign w_win_last  = last_in[w_win];
    assign w_win_inc   = (w_win == c_LAST_IDX) ? '0 : w_win + 1'b1;
    assign w_can_load  = !r_valid || ready_down_in;
    assign w_up_fire   = |(ready_up_out & valid_up_in);

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_up_fire) begin
            case (r_state)
                c_ST_ARB: begin
                    if (w_win_last) begin
                        w_ptr_nxt = w_win_inc;
                    end else begin
                        w_state_nxt = c_ST_LOCK;
                        w_owner_nxt = w_win;
                    end
                end
                default: begin
                    if (w_win_last) begin
                        w_state_nxt = c_ST_ARB;
                        w_ptr_nxt   = w_win_inc;
                    end
                end
            endcase
        end
    end

    // Output logic: gated by rst_n so no ready is offered while in reset
    always_comb begin
        ready_up_out = '0;
        if (rst_n && w_can_load && w_win_valid) begin
            ready_up_out[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else if (w_up_fire) begin
            r_data  <= w_win_data;
            r_last  <= w_win_last;
            r_id    <= w_win;
            r_valid <= 1'b1;
        end else if (ready_down_in) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out       = r_data;
    assign last_out       = r_last;
    assign grant_id_out   = r_id;
    assign valid_down_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_handshake_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_handshake_arbiter
// Description : Directed self-checking bench for rr_handshake_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_handshake_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       last_in;
    logic [NUM_REQ-1:0]       valid_up_in;
    logic [NUM_REQ-1:0]       ready_up_out;
    logic [WIDTH-1:0]         data_out;
    logic                     last_out;
    logic [IDW-1:0]           grant_id_out;
    logic                     valid_down_out;
    logic                     ready_down_in;

    int n_total;
    int n_bad;

    rr_handshake_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .last_in        (last_in),
        .valid_up_in    (valid_up_in),
        .ready_up_out   (ready_up_out),
        .data_out       (data_out),
        .last_out       (last_out),
        .grant_id_out   (grant_id_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic l);
        data_in[i*WIDTH +: WIDTH] = d;
        last_in[i]                = l;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        valid_up_in   = '0;
        last_in       = '0;
        data_in       = '0;
        ready_down_in = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        valid_up_in   = 4'b1111;
        ready_down_in = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hD000_0000 + i, 1'b1);
        tick();
        tick();
        n_total++;
        if (valid_down_out !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid got=%b exp=0", valid_down_out);
        end
        n_total++;
        if (data_out !== 32'h0 || last_out !== 1'b0 || grant_id_out !== 2'd0) begin
            n_bad++; $display("FAIL rst_regs got data=%h last=%b id=%0d exp 0/0/0", data_out, last_out, grant_id_out);
        end
        n_total++;
        if (ready_up_out !== 4'b0000) begin
            n_bad++; $display("FAIL rst_ready got=%b exp=0000", ready_up_out);
        end
        rst_n = 1'b1;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0001) begin
            n_bad++; $display("FAIL rst_first_ready got=%b exp=0001", ready_up_out);
        end
        tick();
        n_total++;
        if (valid_down_out !== 1'b1 || grant_id_out !== 2'd0 || data_out !== 32'hD000_0000) begin
            n_bad++; $display("FAIL rst_first_beat got v=%b id=%0d d=%h exp v=1 id=0 d=d0000000", valid_down_out, grant_id_out, data_out);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hF000_0000 + 32'h11 * i, 1'b1);
        valid_up_in = 4'b1111;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0001) begin
            n_bad++; $display("FAIL fair_ready0 got=%b exp=0001", ready_up_out);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_total++;
            if (valid_down_out !== 1'b1 || grant_id_out !== IDW'(c % 4) ||
                data_out !== 32'hF000_0000 + 32'h11 * (c % 4)) begin
                n_bad++; $display("FAIL fair_beat%0d got v=%b id=%0d d=%h exp v=1 id=%0d", c, valid_down_out, grant_id_out, data_out, c % 4);
            end
            exp_rdy = 4'b0001 << ((c + 1) % 4);
            n_total++;
            if (ready_up_out !== exp_rdy) begin
                n_bad++; $display("FAIL fair_ready%0d got=%b exp=%b", c + 1, ready_up_out, exp_rdy);
            end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        set_req(2, 32'h2222_0001, 1'b0);
        set_req(1, 32'h1111_0001, 1'b1);
        valid_up_in = 4'b0100;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0100) begin
            n_bad++; $display("FAIL lock_ready_b1 got=%b exp=0100", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd2 || data_out !== 32'h2222_0001 || last_out !== 1'b0) begin
            n_bad++; $display("FAIL lock_beat1 got id=%0d d=%h l=%b exp id=2 d=22220001 l=0", grant_id_out, data_out, last_out);
        end
        valid_up_in = 4'b0110;
        set_req(2, 32'h2222_0002, 1'b0);
        #1;
        n_total++;
        if (ready_up_out !== 4'b0100) begin
            n_bad++; $display("FAIL lock_ready_b2 got=%b exp=0100", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd2 || data_out !== 32'h2222_0002) begin
            n_bad++; $display("FAIL lock_beat2 got id=%0d d=%h exp id=2 d=22220002", grant_id_out, data_out);
        end
        set_req(2, 32'h2222_0003, 1'b1);
        #1;
        n_total++;
        if (ready_up_out !== 4'b0100) begin
            n_bad++; $display("FAIL lock_ready_b3 got=%b exp=0100", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd2 || data_out !== 32'h2222_0003 || last_out !== 1'b1) begin
            n_bad++; $display("FAIL lock_beat3 got id=%0d d=%h l=%b exp id=2 d=22220003 l=1", grant_id_out, data_out, last_out);
        end
        set_req(3, 32'h3333_0001, 1'b1);
        valid_up_in = 4'b1010;
        #1;
        n_total++;
        if (ready_up_out !== 4'b1000) begin
            n_bad++; $display("FAIL lock_ptr3 got=%b exp=1000", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd3 || data_out !== 32'h3333_0001) begin
            n_bad++; $display("FAIL lock_after3 got id=%0d d=%h exp id=3", grant_id_out, data_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd1 || data_out !== 32'h1111_0001 || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL lock_after1 got id=%0d d=%h v=%b exp id=1 v=1", grant_id_out, data_out, valid_down_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 32'hA5A5_A5A5, 1'b1);
        valid_up_in = 4'b0001;
        tick();
        n_total++;
        if (data_out !== 32'hA5A5_A5A5 || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL bp_load got d=%h v=%b exp d=a5a5a5a5 v=1", data_out, valid_down_out);
        end
        ready_down_in = 1'b0;
        set_req(1, 32'hB1B1_0000, 1'b1);
        set_req(2, 32'hB2B2_0000, 1'b1);
        valid_up_in = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++;
            if (ready_up_out !== 4'b0000) begin
                n_bad++; $display("FAIL bp_ready%0d got=%b exp=0000", c, ready_up_out);
            end
            tick();
            n_total++;
            if (data_out !== 32'hA5A5_A5A5 || valid_down_out !== 1'b1 || grant_id_out !== 2'd0) begin
                n_bad++; $display("FAIL bp_hold%0d got d=%h v=%b id=%0d exp d=a5a5a5a5 v=1 id=0", c, data_out, valid_down_out, grant_id_out);
            end
        end
        ready_down_in = 1'b1;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0010) begin
            n_bad++; $display("FAIL bp_release_ready got=%b exp=0010", ready_up_out);
        end
        tick();
        n_total++;
        if (data_out !== 32'hB1B1_0000 || grant_id_out !== 2'd1 || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL bp_reload got d=%h id=%0d v=%b exp d=b1b10000 id=1 v=1", data_out, grant_id_out, valid_down_out);
        end
    endtask

    task automatic test_owner_stall();
        do_reset();
        set_req(3, 32'h3000_0001, 1'b0);
        set_req(0, 32'h0000_00AA, 1'b1);
        set_req(1, 32'h1000_00BB, 1'b1);
        valid_up_in = 4'b1000;
        tick();
        n_total++;
        if (grant_id_out !== 2'd3 || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL stall_start got id=%0d v=%b exp id=3 v=1", grant_id_out, valid_down_out);
        end
        valid_up_in = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_total++;
            if (ready_up_out !== 4'b0000) begin
                n_bad++; $display("FAIL stall_ready%0d got=%b exp=0000", c, ready_up_out);
            end
            tick();
            n_total++;
            if (valid_down_out !== 1'b0) begin
                n_bad++; $display("FAIL stall_valid%0d got=%b exp=0", c, valid_down_out);
            end
        end
        set_req(3, 32'h3000_0002, 1'b1);
        valid_up_in = 4'b1011;
        #1;
        n_total++;
        if (ready_up_out !== 4'b1000) begin
            n_bad++; $display("FAIL stall_owner_ready got=%b exp=1000", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd3 || data_out !== 32'h3000_0002 || last_out !== 1'b1) begin
            n_bad++; $display("FAIL stall_owner_last got id=%0d d=%h l=%b exp id=3 d=30000002 l=1", grant_id_out, data_out, last_out);
        end
        valid_up_in = 4'b0011;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0001) begin
            n_bad++; $display("FAIL stall_wrap_ready got=%b exp=0001", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd0 || data_out !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL stall_wrap_beat got id=%0d d=%h exp id=0 d=000000aa", grant_id_out, data_out);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_req(1, 32'h1000_0001, 1'b0);
        valid_up_in = 4'b0010;
        tick();
        n_total++;
        if (grant_id_out !== 2'd1 || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL mid_start got id=%0d v=%b exp id=1 v=1", grant_id_out, valid_down_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (valid_down_out !== 1'b0 || ready_up_out !== 4'b0000) begin
            n_bad++; $display("FAIL mid_async got v=%b rdy=%b exp v=0 rdy=0000", valid_down_out, ready_up_out);
        end
        tick();
        rst_n = 1'b1;
        set_req(0, 32'h0000_0C0C, 1'b1);
        set_req(2, 32'h2000_0C0C, 1'b1);
        valid_up_in = 4'b0101;
        #1;
        n_total++;
        if (ready_up_out !== 4'b0001) begin
            n_bad++; $display("FAIL mid_restart_ready got=%b exp=0001", ready_up_out);
        end
        tick();
        n_total++;
        if (grant_id_out !== 2'd0 || data_out !== 32'h0000_0C0C || valid_down_out !== 1'b1) begin
            n_bad++; $display("FAIL mid_restart_beat got id=%0d d=%h v=%b exp id=0 d=00000c0c v=1", grant_id_out, data_out, valid_down_out);
        end
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        data_in       = '0;
        last_in       = '0;
        valid_up_in   = '0;
        ready_down_in = 1'b1;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_owner_stall();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
